alu_seq_n: RTL and testbench

Parametrised, registered successor to the 2-bit-select combinational logic cell. Computes one of eight logic/arithmetic functions on two WIDTH-bit operands, holds the result in an output register behind a valid/ready handshake, and keeps an internal accumulator that can replace operand A. Sits between an operand source (testbench or sequencer) and a result consumer in the lab datapath.

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_seq_core.sv | 46 ++++
 rtl/alu_seq_n.sv | 79 +++++++
 tb/tb_alu_seq_n.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op-code and width constants shared by the alu_seq blocks
package alu_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OP_W-1:0] OP_INC  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational eight-function unit with carry/no-borrow out
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_op,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum_ext;

    // Select the function; arithmetic uses one extra bit so the carry falls out of the MSB.
    // SUB is A + ~b + 1, so carry = 1 means no borrow.
    always_comb begin
        result  = '0;
        carry   = 1'b0;
        sum_ext = '0;
        case (op)
            OP_AND: result = a_op & b;
            OP_OR:  result = a_op | b;
            OP_XOR: result = a_op ^ b;
            OP_NOR: result = ~(a_op | b);
            OP_ADD: begin
                sum_ext = {1'b0, a_op} + {1'b0, b};
                result  = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                sum_ext = {1'b0, a_op} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result  = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
            end
            OP_INC: begin
                sum_ext = {1'b0, a_op} + {{WIDTH{1'b0}}, 1'b1};
                result  = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
            end
            default: result = b;
        endcase
    end

endmodule

// File: rtl/alu_seq_n.sv
// rtl/alu_seq_n.sv - registered ALU with accumulator and valid/ready output; flags under ALU_SEQ_FLAGS_EN
module alu_seq_n
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_sel,
    input  logic             acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             zero,
    output logic             cout,
`endif
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             accept;

    // Single-entry stage: a new bundle may enter whenever the held result leaves this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign a_op     = acc_sel ? acc : a;

    alu_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_op   (a_op),
        .b      (b),
        .op     (op),
        .result (core_result),
        .carry  (core_carry)
    );

    // Output register, valid bit and accumulator; reset wins over an accept in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= core_result;
            if (acc_wr) begin
                acc <= core_result;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Flags are captured alongside y so they always describe the presented result.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero <= 1'b0;
            cout <= 1'b0;
        end else if (accept) begin
            zero <= (core_result == '0);
            cout <= core_carry;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = core_carry;
`endif

endmodule

// File: tb/tb_alu_seq_n.sv
// tb/tb_alu_seq_n.sv - scoreboard bench for alu_seq_n against a behavioural model
module tb_alu_seq_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [2:0] op = '0;
    logic       acc_sel = 1'b0;
    logic       acc_wr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] y;
`ifdef ALU_SEQ_FLAGS_EN
    logic       zero;
    logic       cout;
`endif

    typedef struct {
        int y;
        int z;
        int c;
    } exp_t;

    exp_t q[$];
    int   macc = 0;
    bit   held = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_n #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_sel   (acc_sel),
        .acc_wr    (acc_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ALU_SEQ_FLAGS_EN
        .zero      (zero),
        .cout      (cout),
`endif
        .y         (y)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: plain modulo-16 arithmetic; SUB has no borrow when A >= b.
    function automatic exp_t model(input int av, input int bv, input int opv);
        exp_t e;
        int s;
        e.c = 0;
        case (opv)
            0: e.y = av & bv;
            1: e.y = av | bv;
            2: e.y = av ^ bv;
            3: e.y = 15 - (av | bv);
            4: begin s = av + bv; e.y = s % 16; e.c = (s >= 16) ? 1 : 0; end
            5: begin e.y = (av - bv + 16) % 16; e.c = (av >= bv) ? 1 : 0; end
            6: begin s = av + 1; e.y = s % 16; e.c = (s >= 16) ? 1 : 0; end
            default: e.y = bv;
        endcase
        e.z = (e.y == 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: a held result must match the oldest expectation; it is retired when consumed.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("y", int'(y), q[0].y);
`ifdef ALU_SEQ_FLAGS_EN
                check("zero", int'(zero), q[0].z);
                check("cout", int'(cout), q[0].c);
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic cycle(input bit v, input int av, input int bv, input int opv,
                         input bit sel, input bit wr, input bit ordy);
        bit   acc_now;
        exp_t e;
        in_valid  = v;
        a         = av[3:0];
        b         = bv[3:0];
        op        = opv[2:0];
        acc_sel   = sel;
        acc_wr    = wr;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready", int'(in_ready), int'(!held || ordy));
        check("out_valid", int'(out_valid), int'(held));
        acc_now = v && (!held || ordy);
        @(posedge clk);
        #1;
        if (acc_now) begin
            e = model(sel ? macc : av, bv, opv);
            q.push_back(e);
            held = 1'b1;
            if (wr) macc = e.y;
        end else if (held && ordy) begin
            held = 1'b0;
        end
    endtask

    task automatic do_reset(input bit v);
        reset     = 1'b1;
        in_valid  = v;
        a         = 4'd3;
        b         = 4'd5;
        op        = 3'b100;
        acc_wr    = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        acc_wr   = 1'b0;
        held     = 1'b0;
        macc     = 0;
        q.delete();
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y", int'(y), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef ALU_SEQ_FLAGS_EN
        check("rst_zero", int'(zero), 0);
        check("rst_cout", int'(cout), 0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0);
        // accumulator starts at zero
        cycle(1, 0, 0, 1, 1, 0, 1);
        // logic sweep
        for (int i = 0; i < 4; i++) cycle(1, 12, 10, i, 0, 0, 1);
        // arithmetic wrap
        cycle(1, 15, 1, 4, 0, 0, 1);
        cycle(1, 3, 5, 5, 0, 0, 1);
        cycle(1, 5, 3, 5, 0, 0, 1);
        // accumulate chain
        cycle(1, 0, 3, 7, 0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 5, 4, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        // backpressure: pending bundle ignored, then taken on release
        cycle(1, 9, 4, 4, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 7, 2, 2, 1, 1, 0);
        cycle(1, 7, 2, 2, 1, 1, 1);
        cycle(1, 0, 0, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        // reset mid-operation with acc = 0110
        cycle(1, 0, 6, 7, 0, 1, 0);
        do_reset(1'b1);
        cycle(1, 0, 0, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 7);
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 1);
        check("drain_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
